// File: rtl/spi_slave_m.sv
// -----------------------------------------------------------------------------
// spi_slave_m
// SPI responder, mode 0 (SCK idle low, MOSI/MISO change on SCK fall, sampled on
// SCK rise), active-low chip select, LSB first. SCK, CS and MOSI are
// asynchronous to CLK; each passes through a SYNC_STAGES-deep synchroniser and
// is edge-detected against one further registered copy.
//
// Ports
//   CLK          system clock, all state on posedge
//   RST          asynchronous reset, active-high
//   CS           SPI chip select, active-low
//   SCK          SPI clock from the master
//   MOSI         master-out data
//   MISO         slave-out data (TX shifter bit 0 while BUSY, else 0)
//   TX_DATA      word to send in the next slot
//   TX_LOAD      write TX_DATA into the single-entry TX buffer
//   TX_READY     TX buffer empty
//   RX_DATA      last complete received word, held until the next completes
//   RX_VALID     1-cycle pulse, RX_DATA updated
//   TX_UNDERRUN  1-cycle pulse, a slot started with the TX buffer empty
//   FRAME_ABORT  1-cycle pulse, CS rose with a partial word
//   BUSY         synchronised CS is low
//
// TX handshake: a word is accepted on any CLK edge where TX_LOAD && TX_READY;
// TX_READY drops on the following cycle. TX_LOAD while TX_READY is low is
// ignored and the buffer keeps its contents. TX_READY rises again when the
// buffer is copied into the TX shifter at a slot start.
// -----------------------------------------------------------------------------
module spi_slave_m #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CS,
  input  logic             SCK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_LOAD,
  output logic             TX_READY,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             TX_UNDERRUN,
  output logic             FRAME_ABORT,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Synchronisers. CS resets to its idle (high) level so that reset never
  // looks like a chip-select fall.
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   cs_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic busy;
  logic sck_rise;
  logic sck_fall;
  logic cs_fall;
  logic cs_rise;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign busy     = ~cs_s;
  // SCK edges only count while selected.
  assign sck_rise = busy & sck_s & ~sck_d;
  assign sck_fall = busy & ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_sh;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] tx_buf;
  logic             tx_ready;
  logic             word_done;  // at least one word completed in this frame
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             frame_abort;
  logic             word_end;
  logic             slot_start;

  // The counter sits at WIDTH for exactly one cycle after the last rise; that
  // cycle publishes the word and returns the counter to zero.
  assign word_end   = (bit_cnt == CNT_FULL);
  // A new slot opens on CS fall, or on the SCK fall that follows a finished
  // word while CS stays low.
  assign slot_start = cs_fall | (sck_fall & (bit_cnt == '0) & word_done);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      tx_buf      <= '0;
      tx_ready    <= 1'b1;
      word_done   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      // TX side. A same-cycle load while empty is not seen by this slot
      // start (tx_ready is still 1 here) and lands in the buffer instead.
      if (slot_start) begin
        if (!tx_ready) begin
          tx_sh    <= tx_buf;
          tx_ready <= 1'b1;
        end else begin
          tx_sh       <= '1;
          tx_underrun <= 1'b1;
        end
      end else if (sck_fall && (bit_cnt != '0)) begin
        tx_sh <= {1'b1, tx_sh[WIDTH-1:1]};
      end

      if (TX_LOAD && tx_ready) begin
        tx_buf   <= TX_DATA;
        tx_ready <= 1'b0;
      end

      // RX side and bit counter.
      if (word_end) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
        bit_cnt  <= '0;
      end else if (cs_rise) begin
        if (bit_cnt != '0) begin
          frame_abort <= 1'b1;
        end
        bit_cnt <= '0;
      end else if (sck_rise) begin
        rx_sh   <= {mosi_s, rx_sh[WIDTH-1:1]};
        bit_cnt <= bit_cnt + CNT_ONE;
      end

      if (cs_fall || cs_rise) begin
        word_done <= 1'b0;
      end else if (word_end) begin
        word_done <= 1'b1;
      end
    end
  end

  assign MISO        = busy & tx_sh[0];
  assign TX_READY    = tx_ready;
  assign RX_DATA     = rx_data;
  assign RX_VALID    = rx_valid;
  assign TX_UNDERRUN = tx_underrun;
  assign FRAME_ABORT = frame_abort;
  assign BUSY        = busy;

endmodule

// File: tb/tb_spi_slave_m.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_m
// Drives spi_slave_m as a mode-0 SPI master and as the local TX producer.
// A behavioural model tracks the single-entry TX buffer at the level of
// "slots" (each slot takes the buffered word or sends all-ones with an
// underrun), the words the master expects to see delivered, and the number
// of underrun/abort pulses a frame must produce.
// -----------------------------------------------------------------------------
module tb_spi_slave_m;

  localparam int W    = 8;
  localparam int SS   = 2;
  localparam int HALF = 6;   // SCK half period in CLK cycles

  logic         CLK;
  logic         RST;
  logic         CS;
  logic         SCK;
  logic         MOSI;
  logic         MISO;
  logic [W-1:0] TX_DATA;
  logic         TX_LOAD;
  logic         TX_READY;
  logic [W-1:0] RX_DATA;
  logic         RX_VALID;
  logic         TX_UNDERRUN;
  logic         FRAME_ABORT;
  logic         BUSY;

  spi_slave_m #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CS          (CS),
    .SCK         (SCK),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .TX_DATA     (TX_DATA),
    .TX_LOAD     (TX_LOAD),
    .TX_READY    (TX_READY),
    .RX_DATA     (RX_DATA),
    .RX_VALID    (RX_VALID),
    .TX_UNDERRUN (TX_UNDERRUN),
    .FRAME_ABORT (FRAME_ABORT),
    .BUSY        (BUSY)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];     // words the slave must deliver, in order
  bit           m_full = 0;   // model TX buffer
  logic [W-1:0] m_buf  = '0;
  logic [W-1:0] cur_tx = '0;  // word the current slot is sending
  logic [W-1:0] last_rx = '0; // RX_DATA the slave should be holding
  bit           m_partial = 0;
  int           exp_und = 0;
  int           exp_abt = 0;
  int           last_rise_cyc = 0;

  task automatic model_slot();
    if (m_full) begin
      cur_tx = m_buf;
      m_full = 0;
    end else begin
      cur_tx = '1;
      exp_und++;
    end
  endtask

  // ---------------- scoreboard / pulse monitor ----------------
  int n_rx  = 0;
  int n_und = 0;
  int n_abt = 0;

  always @(negedge CLK) begin
    if (RX_VALID) begin
      n_rx++;
      check("rx_pending", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        check("rx_data", 32'(RX_DATA), 32'(exp_q.pop_front()));
        check("rx_latency", 32'(cyc - last_rise_cyc), 32'(SS + 2));
      end
    end
    if (TX_UNDERRUN) n_und++;
    if (FRAME_ABORT) n_abt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tx_load(input logic [W-1:0] d);
    @(negedge CLK);
    TX_DATA = d;
    TX_LOAD = 1'b1;
    if (!m_full) begin
      m_full = 1;
      m_buf  = d;
    end
    @(negedge CLK);
    TX_LOAD = 1'b0;
  endtask

  task automatic cs_assert();
    @(negedge CLK);
    CS = 1'b0;
    m_partial = 0;
    model_slot();
    repeat (8) @(negedge CLK);
  endtask

  task automatic cs_release();
    @(negedge CLK);
    CS = 1'b1;
    if (m_partial) exp_abt++;
    m_partial = 0;
    repeat (8) @(negedge CLK);
  endtask

  // One word (or a partial word of nbits) from the master; optionally a
  // TX_LOAD in the middle of the word.
  task automatic master_word(input logic [W-1:0] mosi_w, input int nbits,
                             input bit do_load, input logic [W-1:0] load_d);
    logic [W-1:0] got;
    got = '0;
    if (nbits == W) exp_q.push_back(mosi_w);
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_w[i];
      repeat (HALF) @(negedge CLK);
      got[i] = MISO;
      SCK = 1'b1;
      last_rise_cyc = cyc;
      repeat (HALF) @(negedge CLK);
      SCK = 1'b0;
      if (do_load && i == 3) tx_load(load_d);
    end
    repeat (HALF) @(negedge CLK);
    if (nbits == W) begin
      check("miso_word", 32'(got), 32'(cur_tx));
      last_rx = mosi_w;
      model_slot();  // trailing SCK fall opens the next slot
    end else begin
      m_partial = 1;
    end
  endtask

  task automatic frame_end_checks();
    check("und_count", 32'(n_und), 32'(exp_und));
    check("abt_count", 32'(n_abt), 32'(exp_abt));
    check("rx_drained", 32'(exp_q.size()), 32'(0));
    check("rx_hold", 32'(RX_DATA), 32'(last_rx));
    check("tx_ready", 32'(TX_READY), 32'(!m_full));
    check("busy_idle", 32'(BUSY), 32'(0));
    check("miso_idle", 32'(MISO), 32'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  int u0;
  int r0;
  int a0;

  initial begin
    RST = 1'b1; CS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
    TX_DATA = '0; TX_LOAD = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_miso", 32'(MISO), 32'(0));
    check("rst_tx_ready", 32'(TX_READY), 32'(1));
    check("rst_rx_data", 32'(RX_DATA), 32'(0));
    check("rst_rx_valid", 32'(RX_VALID), 32'(0));
    check("rst_underrun", 32'(TX_UNDERRUN), 32'(0));
    check("rst_abort", 32'(FRAME_ABORT), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // Single word: slave sends 0xA5, master sends 0x3C
    tx_load(8'hA5);
    check("t2_ready_after_load", 32'(TX_READY), 32'(0));
    cs_assert();
    check("t2_ready_after_csfall", 32'(TX_READY), 32'(1));
    check("t2_busy", 32'(BUSY), 32'(1));
    check("t2_first_bit", 32'(MISO), 32'(1));
    master_word(8'h3C, W, 0, '0);
    check("t2_rx", 32'(RX_DATA), 32'(8'h3C));
    cs_release();
    frame_end_checks();

    // Two-word frame: 0x11 preloaded, 0x22 loaded during word 1
    tx_load(8'h11);
    cs_assert();
    master_word(8'h81, W, 1, 8'h22);
    master_word(8'h7E, W, 0, '0);
    cs_release();
    frame_end_checks();

    // Underrun at CS fall
    u0 = n_und;
    cs_assert();
    check("t4_und_at_csfall", 32'(n_und - u0), 32'(1));
    master_word(8'h55, W, 0, '0);
    cs_release();
    check("t4_rx", 32'(RX_DATA), 32'(8'h55));
    frame_end_checks();

    // Abort after 5 rises, then a clean 0xF0
    r0 = n_rx;
    cs_assert();
    master_word(8'($urandom), 5, 0, '0);
    cs_release();
    check("t5_no_rx_valid", 32'(n_rx - r0), 32'(0));
    check("t5_rx_kept", 32'(RX_DATA), 32'(8'h55));
    frame_end_checks();
    cs_assert();
    master_word(8'hF0, W, 0, '0);
    cs_release();
    frame_end_checks();

    // Ignored second load: master must receive 0x12
    tx_load(8'h12);
    tx_load(8'h34);
    check("t6_ready_low", 32'(TX_READY), 32'(0));
    cs_assert();
    check("t6_slot_word", 32'(cur_tx), 32'(8'h12));
    master_word(8'($urandom), W, 0, '0);
    cs_release();
    frame_end_checks();

    // SCK activity with CS high must be ignored
    r0 = n_rx;
    a0 = n_abt;
    for (int i = 0; i < 20; i++) begin
      MOSI = 1'($urandom);
      SCK = ~SCK;
      repeat (HALF) @(negedge CLK);
    end
    SCK = 1'b0;
    repeat (HALF) @(negedge CLK);
    check("t6_cs_high_no_rx", 32'(n_rx - r0), 32'(0));
    cs_assert();
    cs_release();
    check("t6_cs_high_no_abort", 32'(n_abt - a0), 32'(0));
    frame_end_checks();

    // Reset in mid-frame
    tx_load(8'($urandom) | 8'h01);
    cs_assert();
    master_word(8'($urandom), 3, 0, '0);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_busy", 32'(BUSY), 32'(0));
    check("mid_rst_miso", 32'(MISO), 32'(0));
    check("mid_rst_tx_ready", 32'(TX_READY), 32'(1));
    check("mid_rst_rx_data", 32'(RX_DATA), 32'(0));
    CS = 1'b1; SCK = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    m_full = 0; m_partial = 0; last_rx = '0;
    exp_q.delete();
    repeat (4) @(negedge CLK);
    frame_end_checks();

    // Randomised frames
    for (int f = 0; f < 20; f++) begin
      int nwords;
      nwords = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) tx_load(8'($urandom));
      cs_assert();
      for (int k = 0; k < nwords; k++) begin
        int nb;
        nb = W;
        if (k == nwords - 1 && $urandom_range(0, 4) == 0) nb = $urandom_range(1, W - 1);
        master_word(8'($urandom), nb, 1'($urandom_range(0, 1)), 8'($urandom));
      end
      cs_release();
      frame_end_checks();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
